// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: one command becomes one classic or
// linear incrementing-burst cycle, with streamed write and read data.
module wb_burst_master #(
    parameter int dw = 32,
    parameter int aw = 32,
    parameter int LW = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [aw-1:0]   cmd_adr_i,
    input  logic [LW-1:0]   cmd_len_i,
    input  logic [dw-1:0]   wdat_i,
    input  logic            wdat_valid_i,
    output logic            wdat_ready_o,
    output logic [dw-1:0]   rdat_o,
    output logic            rdat_valid_o,
    output logic            done_o,
    output logic            err_o,
    output logic [aw-1:0]   wb_adr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic [1:0]      wb_bte_o,
    output logic [2:0]      wb_cti_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i,
    input  logic [dw-1:0]   wb_dat_i
);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t          r_state;
    logic            r_we;
    logic [aw-1:0]   r_adr;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_bcnt;
    logic            r_cyc;
    logic [dw-1:0]   r_rdat;
    logic            r_rvld;
    logic            r_done;
    logic            r_err;

    logic            w_burst;
    logic            w_stb;
    logic            w_term;
    logic            w_beat;
    logic            w_last;
    logic [2:0]      w_cti;

    assign w_burst = (r_state == S_BURST);
    assign w_stb   = w_burst & (!r_we | wdat_valid_i);
    // err/rty take precedence: a terminated beat never counts as acked
    assign w_term  = r_cyc & (wb_err_i | wb_rty_i);
    assign w_beat  = wb_ack_i & w_stb & !w_term;
    assign w_last  = (r_bcnt == r_len);

    always_comb begin
        w_cti = 3'b000;
        if (w_burst && (r_len != '0)) begin
            w_cti = w_last ? 3'b111 : 3'b010;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_len   <= '0;
            r_bcnt  <= '0;
            r_cyc   <= 1'b0;
            r_rdat  <= '0;
            r_rvld  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_rvld <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_state <= S_BURST;
                        r_cyc   <= 1'b1;
                        r_we    <= cmd_we_i;
                        r_adr   <= cmd_adr_i;
                        r_len   <= cmd_len_i;
                        r_bcnt  <= '0;
                    end
                end
                S_BURST: begin
                    if (w_term) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (w_beat) begin
                        r_adr  <= r_adr + aw'(1);
                        r_bcnt <= r_bcnt + LW'(1);
                        if (!r_we) begin
                            r_rdat <= wb_dat_i;
                            r_rvld <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_cyc   <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = (r_state == S_IDLE);
    assign wdat_ready_o = w_beat & r_we;
    assign rdat_o       = r_rdat;
    assign rdat_valid_o = r_rvld;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = wdat_i;
    assign wb_sel_o     = '1;
    assign wb_we_o      = r_we;
    assign wb_bte_o     = 2'b00;
    assign wb_cti_o     = w_cti;
    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = w_stb;

endmodule
